// File: rtl/jtframe_db15_tx.sv
// DB15 serial joystick adapter emulator: answers host LOAD/CLK strobes by
// shifting {joy2, joy1} out LSB-first on an active-low serial line.
module jtframe_db15_tx #(
   parameter logic [15:0] WDOG = 16'd4800
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] joy1,
   input  logic [15:0] joy2,
   input  logic        joy_load,
   input  logic        joy_clk,
   output logic        joy_data,
   output logic        frame_done,
   output logic        active
);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

   state_t      state, state_next;
   logic [2:0]  load_sync, clk_sync;
   logic [31:0] sr, sr_next;
   logic [5:0]  count, count_next;
   logic [15:0] wd, wd_next;
   logic        done_next;
   logic        load_low, load_rise, clk_rise;

   // Bit 0 is the first synchroniser stage, bit 2 the edge-detect stage
   assign load_low  = ~load_sync[1];
   assign load_rise = load_sync[1] & ~load_sync[2];
   assign clk_rise  = clk_sync[1] & ~clk_sync[2];
   assign active    = (state == LOAD) || (state == SHIFT);

   always_comb begin
      state_next = state;
      sr_next    = sr;
      count_next = count;
      wd_next    = wd;
      done_next  = 1'b0;
      case (state)
         IDLE: begin
            if (load_low) state_next = LOAD;
         end
         LOAD: begin
            sr_next    = ~{joy2, joy1};
            count_next = 6'd0;
            if (load_rise) state_next = SHIFT;
         end
         SHIFT: begin
            // A reload request beats a simultaneous shift clock
            if (load_low) begin
               state_next = LOAD;
            end else if (clk_rise) begin
               sr_next = {1'b1, sr[31:1]};
               wd_next = 16'd0;
               if (count == 6'd31) begin
                  count_next = 6'd32;
                  done_next  = 1'b1;
                  state_next = DONE;
               end else if (count != 6'd32) begin
                  count_next = count + 6'd1;
               end
            end else if (wd == WDOG - 16'd1) begin
               state_next = IDLE;
            end else begin
               wd_next = wd + 16'd1;
            end
         end
         DONE: begin
            if (load_low) state_next = LOAD;
         end
         default: state_next = IDLE;
      endcase
      if (state_next != state) wd_next = 16'd0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         load_sync  <= 3'b111;
         clk_sync   <= 3'b111;
         state      <= IDLE;
         sr         <= '1;
         count      <= 6'd0;
         wd         <= 16'd0;
         joy_data   <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         load_sync  <= {load_sync[1:0], joy_load};
         clk_sync   <= {clk_sync[1:0], joy_clk};
         state      <= state_next;
         sr         <= sr_next;
         count      <= count_next;
         wd         <= wd_next;
         joy_data   <= (state == IDLE || state == DONE) ? 1'b1 : sr[0];
         frame_done <= done_next;
      end
   end

endmodule

// File: tb/tb_jtframe_db15_tx.sv
// Scoreboard bench for jtframe_db15_tx: stimulus pushes expected outputs,
// a negedge monitor pops and compares them against the pins.
module tb_jtframe_db15_tx;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] joy1 = 16'h0000;
   logic [15:0] joy2 = 16'h0000;
   logic        joy_load = 1'b1;
   logic        joy_clk = 1'b0;
   logic        joy_data, frame_done, active;

   always #5 clk = ~clk;

   jtframe_db15_tx #(.WDOG(16'd64)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .joy1       (joy1),
      .joy2       (joy2),
      .joy_load   (joy_load),
      .joy_clk    (joy_clk),
      .joy_data   (joy_data),
      .frame_done (frame_done),
      .active     (active)
   );

   typedef struct {
      string name;
      logic  data;
      logic  act;
      logic  done;
      int    cnt;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   done_seen = 0;
   int   exp_done = 0;

   // Compare one scoreboard entry against the pins, one check per output
   task automatic checkOutput(input exp_t e);
      checks++;
      if (joy_data !== e.data) begin
         errors++;
         $display("[TB] FAIL %s joy_data: got %b, want %b", e.name, joy_data, e.data);
      end
      checks++;
      if (active !== e.act) begin
         errors++;
         $display("[TB] FAIL %s active: got %b, want %b", e.name, active, e.act);
      end
      checks++;
      if (frame_done !== e.done) begin
         errors++;
         $display("[TB] FAIL %s frame_done: got %b, want %b", e.name, frame_done, e.done);
      end
      checks++;
      if (done_seen != e.cnt) begin
         errors++;
         $display("[TB] FAIL %s frame_done pulses: got %0d, want %0d", e.name, done_seen, e.cnt);
      end
   endtask

   // Monitor: counts frame_done pulses and drains the scoreboard mid-cycle
   initial begin
      forever begin
         @(negedge clk);
         if (frame_done === 1'b1) done_seen++;
         while (sb.size() > 0) checkOutput(sb.pop_front());
      end
   end

   task automatic expectOutput(input string name, input logic data, input logic act,
                               input logic done);
      exp_t e;
      e.name = name;
      e.data = data;
      e.act  = act;
      e.done = done;
      e.cnt  = exp_done;
      sb.push_back(e);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [15:0] j1, input logic [15:0] j2,
                                input logic ld, input logic ck);
      joy1     = j1;
      joy2     = j2;
      joy_load = ld;
      joy_clk  = ck;
   endtask

   task automatic loadWords(input logic [15:0] j1, input logic [15:0] j2);
      applyStimulus(j1, j2, 1'b0, 1'b0);
      tick(8);
      expectOutput("load low", ~j1[0], 1'b1, 1'b0);
      applyStimulus(j1, j2, 1'b1, 1'b0);
      tick(8);
   endtask

   // w is the expected serial word (already inverted); bits past 31 read 1
   task automatic shiftBits(input logic [31:0] w, input int first, input int last);
      for (int i = first; i <= last; i++) begin
         logic [4:0] idx;
         logic       exp_bit;
         idx     = i[4:0];
         exp_bit = (i < 32) ? w[idx] : 1'b1;
         expectOutput($sformatf("bit %0d", i), exp_bit, i < 32, 1'b0);
         joy_clk = 1'b1;
         if (i == 31) begin
            tick(2);
            expectOutput("pre 32nd shift", w[31], 1'b1, 1'b0);
            tick(1);
            exp_done++;
            expectOutput("32nd shift", w[31], 1'b0, 1'b1);
            tick(1);
            expectOutput("after done", 1'b1, 1'b0, 1'b0);
            tick(5);
         end else begin
            tick(8);
         end
         joy_clk = 1'b0;
         tick(8);
      end
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL timeout: simulation did not complete");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      // Reset with random inputs
      rst_n = 1'b0;
      repeat (3) begin
         applyStimulus(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)));
         tick(1);
      end
      expectOutput("in reset", 1'b1, 1'b0, 1'b0);
      rst_n = 1'b1;
      applyStimulus(16'h0000, 16'h0000, 1'b1, 1'b0);
      tick(10);
      expectOutput("idle after reset", 1'b1, 1'b0, 1'b0);

      // Full frame: ~{8001, 0A05} = 7FFE_F5FA
      loadWords(16'h0A05, 16'h8001);
      shiftBits(32'h7FFE_F5FA, 0, 31);
      tick(4);
      expectOutput("after frame", 1'b1, 1'b0, 1'b0);

      // Over-clocking: 40 pulses, only one frame_done
      loadWords(16'h0A05, 16'h8001);
      shiftBits(32'h7FFE_F5FA, 0, 39);

      // Abort after 10 shifts, reload with joy1 = 0001: ~{8001, 0001} = 7FFE_FFFE
      loadWords(16'h0A05, 16'h8001);
      shiftBits(32'h7FFE_F5FA, 0, 9);
      loadWords(16'h0001, 16'h8001);
      expectOutput("first bit after abort", 1'b0, 1'b1, 1'b0);
      shiftBits(32'h7FFE_FFFE, 0, 31);

      // Watchdog: ~{8001, 00F0} = 7FFE_FF0F, 5 shifts then stall
      loadWords(16'h00F0, 16'h8001);
      shiftBits(32'h7FFE_FF0F, 0, 3);
      expectOutput("wd bit 4", 1'b0, 1'b1, 1'b0);
      joy_clk = 1'b1;
      tick(8);
      joy_clk = 1'b0;
      tick(58);
      expectOutput("wd one before", 1'b0, 1'b1, 1'b0);
      tick(1);
      expectOutput("wd fired", 1'b0, 1'b0, 1'b0);
      tick(1);
      expectOutput("wd idle data", 1'b1, 1'b0, 1'b0);

      // Mid-frame reset during shift 20, then a clean frame
      loadWords(16'h0A05, 16'h8001);
      shiftBits(32'h7FFE_F5FA, 0, 19);
      joy_clk = 1'b1;
      tick(3);
      rst_n = 1'b0;
      tick(1);
      expectOutput("mid-frame reset", 1'b1, 1'b0, 1'b0);
      rst_n = 1'b1;
      tick(4);
      joy_clk = 1'b0;
      tick(8);
      expectOutput("idle after mid reset", 1'b1, 1'b0, 1'b0);
      loadWords(16'h0A05, 16'h8001);
      shiftBits(32'h7FFE_F5FA, 0, 31);
      tick(4);
      expectOutput("after final frame", 1'b1, 1'b0, 1'b0);

      tick(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/jtframe_db15_tx.md
# jtframe_db15_tx

Emulates the DB15 serial joystick adapter: it answers a host reader's LOAD/CLK strobes by shifting two 16-bit button words out on one active-low serial data line. The block sits on the user-port side of a test or adapter core, feeding the same serial protocol that the MiSTer DB15 reader consumes. Bench models and loop-back cores use it to exercise the reader without hardware.

## Interface
Parameters:
- WDOG, 16'd4800, watchdog length in clk cycles (100 µs at 48 MHz). If SHIFT sees no CLK rising edge for this long, the frame aborts.

Ports:
- clk  in  1  system clock (48 MHz nominal)
- rst_n  in  1  reset, synchronous, active low
- joy1  in  16  player 1 buttons, active high. Layout: bit 0 R, 1 L, 2 D, 3 U, 4–9 A–F, 10 Start, 11 Coin, 15:12 spare.
- joy2  in  16  player 2 buttons, same layout
- joy_load  in  1  host load strobe, asynchronous, active low
- joy_clk  in  1  host shift clock, asynchronous, shifts on rising edge
- joy_data  out  1  serial data to host, active low (0 = pressed)
- frame_done  out  1  one-cycle pulse when the 32nd bit has been shifted
- active  out  1  high in LOAD and SHIFT states

## Operation
- Synchronisers: joy_load and joy_clk each pass through 2 flops, then a third flop for edge detection. All logic below uses the synchronised signals only.
- Shift register: 32 bits, {joy2, joy1} inverted, so the first bit out is ~joy1[0]. The register shifts LSB-first with 1 filled in at the MSB. joy_data is a registered copy of sr[0].
- Bit counter: 6 bits, saturating at 32.
- Watchdog: 16-bit counter. Clears on every sync'd CLK rising edge and on every state change. Runs only in SHIFT.
- States:
  - IDLE: joy_data = 1. Sync'd load low → LOAD.
  - LOAD: every cycle, sr <= ~{joy2, joy1} (transparent load, like a '165) and count <= 0. CLK edges are ignored. Sync'd load high → SHIFT; sr holds the last loaded value.
  - SHIFT: on each CLK rising edge, sr shifts and count increments. When count reaches 32, pulse frame_done and go to DONE. Watchdog reaching WDOG → IDLE with no frame_done. Sync'd load low → LOAD (abort and reload, no frame_done).
  - DONE: joy_data = 1. Further CLK edges are ignored. Sync'd load low → LOAD.
- Outputs after rst_n low at a clk edge:
  - joy_data = 1, frame_done = 0, active = 0
  - state = IDLE, sr = all ones, count = 0, watchdog = 0
  - synchroniser flops = 1
- Reset wins over every other event, including mid-frame.
- A simultaneous sync'd load fall and CLK rise in SHIFT: load has priority, so the frame aborts.

## Timing
- Pin-to-action latency is 3 clk (sync + edge). joy_data reflects the change 1 clk later: 4 clk from host edge to data valid.
- Requirements on the host:
  - CLK high and low phases ≥ 4 clk each.
  - LOAD low ≥ 4 clk.
  - Sample joy_data no earlier than 5 clk after the CLK rising edge, or just before the next rising edge.
- First bit (~joy1[0]) is valid 4 clk after the LOAD rising edge, before any CLK edge.
- frame_done is high for exactly 1 clk, in the same cycle as the 32nd shift. joy_data goes to 1 on the following clk.
- The watchdog abort fires exactly WDOG clk after the last sync'd CLK edge.

## Test plan
- Reset: hold rst_n low 3 clk with random inputs → joy_data = 1, frame_done = 0, active = 0. After release, 10 clk with no strobes keeps the same values.
- Full frame: joy1 = 16'h0A05, joy2 = 16'h8001; LOAD low 8 clk then high, 32 CLK pulses of 8 clk high / 8 clk low; sample before each rise.
  - Samples are 32 bits equal to ~{16'h8001, 16'h0A05}, LSB first.
  - frame_done pulses once, on the 32nd edge.
  - joy_data = 1 afterwards.
- Over-clocking: 40 CLK pulses after one load → bits 33–40 read 1; frame_done pulses only once.
- Abort: LOAD low after 10 shifts with joy1 changed to 16'h0001 → no frame_done. The next frame's first bit is 0 (bit 0 pressed).
- Watchdog: WDOG = 64 for test; 5 shifts then CLK stalls → exactly 64 clk after the last sync'd edge, active = 0 and joy_data = 1, with no frame_done.
- Mid-frame reset: rst_n low for 1 clk during shift 20 → all outputs at reset values next clk. A following normal frame is bit-exact.
